// File: rtl/bin2bcd_serial.sv
// Purpose: iterative double-dabble binary-to-packed-BCD converter feeding the seven-segment digit stage.
// Latency: result valid WIDTH edges after the accepting edge; next accept no sooner than WIDTH+2 edges apart.
// Backpressure: result held on out_valid until out_ready; in_ready stays low until then (no queuing).
module bin2bcd_serial #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk_5MHz,
    input  logic                  reset_n,
    input  logic [WIDTH-1:0]      bin_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int AW = 4 * DIGITS;
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [WIDTH-1:0]  sr;
    logic [AW-1:0]     acc;

    logic [AW-1:0]     acc_adj;
    logic [AW-1:0]     acc_shl;
    logic [WIDTH-1:0]  sr_shl;
    logic              carry;

    // Per-digit +3 correction, then one-bit left shift of {accumulator, shift register}.
    // The bit leaving the top digit is exactly the carry into a digit we do not keep,
    // so dropping it yields value mod 10^DIGITS and flags overflow.
    always_comb begin
        acc_adj = acc;
        for (int d = 0; d < DIGITS; d++) begin
            if (acc[4*d +: 4] >= 4'd5) begin
                acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
            end
        end
        carry   = acc_adj[AW-1];
        acc_shl = {acc_adj[AW-2:0], sr[WIDTH-1]};
        sr_shl  = sr << 1;
    end

    // Control FSM with all handshake outputs and the result registered.
    always_ff @(posedge clk_5MHz or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            bcd_out   <= '0;
            overflow  <= 1'b0;
            cnt       <= '0;
            sr        <= '0;
            acc       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // in_ready is low only on the first edge after reset release.
                    if (!in_ready) begin
                        in_ready <= 1'b1;
                    end else if (in_valid) begin
                        sr       <= bin_in;
                        acc      <= '0;
                        overflow <= 1'b0;
                        cnt      <= CNT_LOAD;
                        state    <= SHIFT;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                SHIFT: begin
                    acc <= acc_shl;
                    sr  <= sr_shl;
                    cnt <= cnt - CW'(1);
                    if (carry) begin
                        overflow <= 1'b1;
                    end
                    if (cnt == CNT_LAST) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        bcd_out   <= acc_shl;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
